// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs a 32-bit big-endian word stream into 512-bit blocks and drives the core.
// Define SHA1_PADDER_ERR_EN to enable the sticky protocol-error flag on err.
module sha1_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  input  logic [2:0]   s_nbytes,
  input  logic         core_ready,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] core_block,
  output logic         busy,
  output logic         msg_done,
  output logic         err
);

  typedef enum logic [1:0] {FILL, ISSUE, WAIT, PAD} state_t;

  state_t            state;
  logic [3:0]        idx;
  logic [0:15][31:0] blk;
  logic [LEN_W-1:0]  len;
  logic              first, final_blk, pad_pend, pad_80, wait_first, busy_q;

  logic              hs, wait_done;
  logic [2:0]        nb;
  logic [6:0]        p;
  logic [LEN_W-1:0]  len_sum;
  logic [63:0]       len64_sum, len64;
  logic [31:0]       last_word;

  assign s_ready    = (state == FILL);
  assign hs         = s_valid && s_ready;
  assign nb         = (s_nbytes > 3'd4) ? 3'd4 : s_nbytes;
  assign p          = {1'b0, idx, 2'b00} + {4'b0000, nb};
  assign len_sum    = len + (s_last ? LEN_W'({nb, 3'b000}) : LEN_W'(32));
  assign len64_sum  = 64'(len_sum);
  assign len64      = 64'(len);

  // The first WAIT cycle still sees the core's pre-pulse ready, so it is skipped.
  assign wait_done  = (state == WAIT) && !wait_first && core_ready;
  assign core_init  = (state == ISSUE) && core_ready && first;
  assign core_next  = (state == ISSUE) && core_ready && !first;
  assign msg_done   = wait_done && final_blk;
  assign busy       = busy_q;
  assign core_block = blk;

  always_comb begin
    last_word = s_data;
    for (int k = 0; k < 4; k++) begin
      if (k == int'(nb))     last_word[31-8*k -: 8] = 8'h80;
      else if (k > int'(nb)) last_word[31-8*k -: 8] = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FILL;
      idx        <= '0;
      blk        <= '0;
      len        <= '0;
      first      <= 1'b1;
      final_blk  <= 1'b0;
      pad_pend   <= 1'b0;
      pad_80     <= 1'b0;
      wait_first <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        FILL: if (hs) begin
          busy_q   <= 1'b1;
          blk[idx] <= s_last ? last_word : s_data;
          idx      <= idx + 4'd1;
          len      <= len_sum;
          if (s_last) begin
            if (nb == 3'd4 && p < 7'd64) blk[idx + 4'd1][31:24] <= 8'h80;
            if (p <= 7'd55) begin
              blk[14]   <= len64_sum[63:32];
              blk[15]   <= len64_sum[31:0];
              final_blk <= 1'b1;
              pad_pend  <= 1'b0;
            end else begin
              // Length does not fit: a separate pad block follows this one.
              final_blk <= 1'b0;
              pad_pend  <= 1'b1;
              pad_80    <= (p == 7'd64);
            end
            state <= ISSUE;
          end else if (idx == 4'd15) begin
            final_blk <= 1'b0;
            pad_pend  <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: if (core_ready) begin
          first      <= 1'b0;
          wait_first <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          wait_first <= 1'b0;
          if (wait_done) begin
            blk <= '0;
            idx <= '0;
            if (final_blk) begin
              len       <= '0;
              first     <= 1'b1;
              busy_q    <= 1'b0;
              final_blk <= 1'b0;
              state     <= FILL;
            end else if (pad_pend) begin
              state <= PAD;
            end else begin
              state <= FILL;
            end
          end
        end
        PAD: begin
          if (pad_80) blk[0][31:24] <= 8'h80;
          blk[14]   <= len64[63:32];
          blk[15]   <= len64[31:0];
          final_blk <= 1'b1;
          pad_pend  <= 1'b0;
          state     <= ISSUE;
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef SHA1_PADDER_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (hs && s_last && (s_nbytes > 3'd4 || (s_nbytes == 3'd0 && idx != 4'd0)))
      err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sha1_padder.sv
// Directed bench for sha1_padder with a small timing model of the SHA-1 core's ready handshake.
module tb_sha1_padder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         s_valid, s_last, s_ready;
  logic [31:0]  s_data;
  logic [2:0]   s_nbytes;
  logic         core_ready = 1'b1;
  logic         core_init, core_next, busy, msg_done, err;
  logic [511:0] core_block;

  int nvec = 0;
  int nerr = 0;

  int           cnt = 0;
  int           n_pulse = 0;
  int           n_done = 0;
  logic [511:0] cap [0:31];
  logic         cap_init [0:31];

  sha1_padder dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .s_nbytes(s_nbytes),
    .core_ready(core_ready), .core_init(core_init), .core_next(core_next),
    .core_block(core_block), .busy(busy), .msg_done(msg_done), .err(err)
  );

  always #5 clk = ~clk;

  // Core model: captures the block on the pulse, drops ready next cycle, busy for 4 cycles.
  always @(posedge clk) begin
    if (core_init || core_next) begin
      if (n_pulse < 32) begin
        cap[n_pulse]      <= core_block;
        cap_init[n_pulse] <= core_init;
      end
      n_pulse    <= n_pulse + 1;
      core_ready <= 1'b0;
      cnt        <= 3;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) core_ready <= 1'b1;
    end
    if (msg_done) n_done <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    nvec++;
    nerr++;
    $error("FAIL %s: timed out", tag);
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [2:0] nb);
    int t = 0;
    s_valid = 1'b1; s_data = d; s_last = l; s_nbytes = nb;
    while (!s_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) tmo("send");
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_msg(input int nw, input logic [31:0] base, input logic [2:0] lnb);
    for (int i = 0; i < nw; i++)
      send(base + 32'(i), i == nw - 1, (i == nw - 1) ? lnb : 3'd4);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (n_done < target && t < 1000) begin @(negedge clk); t++; end
    if (n_done < target) tmo("msg_done");
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".s_ready"},    512'(s_ready),   512'(1));
    chk({tag, ".core_init"},  512'(core_init), 512'(0));
    chk({tag, ".core_next"},  512'(core_next), 512'(0));
    chk({tag, ".core_block"}, core_block,      512'(0));
    chk({tag, ".busy"},       512'(busy),      512'(0));
    chk({tag, ".msg_done"},   512'(msg_done),  512'(0));
    chk({tag, ".err"},        512'(err),       512'(0));
  endtask

  logic [0:15][31:0] e;
  int m0, d0, t;

  initial begin
    reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_nbytes = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // "abc"
    m0 = n_pulse; d0 = n_done;
    send(32'h61626300, 1'b1, 3'd3);
    chk("abc.busy", 512'(busy), 512'(1));
    wait_done(d0 + 1);
    e = '0; e[0] = 32'h61626380; e[15] = 32'h18;
    chk("abc.npulse", 512'(n_pulse - m0), 512'(1));
    chk("abc.init",   512'(cap_init[m0]), 512'(1));
    chk("abc.block",  cap[m0], e);
    chk("abc.busy_after", 512'(busy), 512'(0));

    // empty message
    m0 = n_pulse; d0 = n_done;
    send(32'h0, 1'b1, 3'd0);
    wait_done(d0 + 1);
    e = '0; e[0] = 32'h80000000;
    chk("empty.npulse", 512'(n_pulse - m0), 512'(1));
    chk("empty.init",   512'(cap_init[m0]), 512'(1));
    chk("empty.block",  cap[m0], e);

    // 55 bytes: length still fits in one block
    m0 = n_pulse; d0 = n_done;
    send_msg(14, 32'h10000000, 3'd3);
    wait_done(d0 + 1);
    e = '0;
    for (int i = 0; i < 13; i++) e[i] = 32'h10000000 + 32'(i);
    e[13] = 32'h10000080; e[15] = 32'h1B8;
    chk("p55.npulse", 512'(n_pulse - m0), 512'(1));
    chk("p55.block",  cap[m0], e);

    // 56 bytes: 0x80 in word 14, length in a pad block
    m0 = n_pulse; d0 = n_done;
    send_msg(14, 32'hA0000000, 3'd4);
    wait_done(d0 + 1);
    e = '0;
    for (int i = 0; i < 14; i++) e[i] = 32'hA0000000 + 32'(i);
    e[14] = 32'h80000000;
    chk("p56.npulse", 512'(n_pulse - m0), 512'(2));
    chk("p56.ndone",  512'(n_done - d0), 512'(1));
    chk("p56.kind0",  512'(cap_init[m0]), 512'(1));
    chk("p56.kind1",  512'(cap_init[m0+1]), 512'(0));
    chk("p56.blk0",   cap[m0], e);
    e = '0; e[15] = 32'h1C0;
    chk("p56.blk1",   cap[m0+1], e);

    // 57 bytes: 0x80 inside the last word, pad block holds only the length
    m0 = n_pulse; d0 = n_done;
    send_msg(15, 32'hB0000000, 3'd1);
    wait_done(d0 + 1);
    e = '0;
    for (int i = 0; i < 14; i++) e[i] = 32'hB0000000 + 32'(i);
    e[14] = 32'hB0800000;
    chk("p57.npulse", 512'(n_pulse - m0), 512'(2));
    chk("p57.blk0",   cap[m0], e);
    e = '0; e[15] = 32'h1C8;
    chk("p57.blk1",   cap[m0+1], e);

    // 64 bytes: raw data block, then 0x80 + length
    m0 = n_pulse; d0 = n_done;
    send_msg(16, 32'hC0000000, 3'd4);
    wait_done(d0 + 1);
    e = '0;
    for (int i = 0; i < 16; i++) e[i] = 32'hC0000000 + 32'(i);
    chk("p64.npulse", 512'(n_pulse - m0), 512'(2));
    chk("p64.kind1",  512'(cap_init[m0+1]), 512'(0));
    chk("p64.blk0",   cap[m0], e);
    e = '0; e[0] = 32'h80000000; e[15] = 32'h200;
    chk("p64.blk1",   cap[m0+1], e);

    // back-to-back messages with s_valid held high
    m0 = n_pulse; d0 = n_done;
    send(32'h11223344, 1'b0, 3'd4);
    send(32'h55667788, 1'b1, 3'd2);
    chk("b2b.s_ready_issue", 512'(s_ready), 512'(0));
    send(32'h77AABBCC, 1'b1, 3'd1);
    wait_done(d0 + 2);
    chk("b2b.npulse", 512'(n_pulse - m0), 512'(2));
    e = '0; e[0] = 32'h11223344; e[1] = 32'h55668000; e[15] = 32'h30;
    chk("b2b.blkA", cap[m0], e);
    e = '0; e[0] = 32'h77800000; e[15] = 32'h8;
    chk("b2b.blkB", cap[m0+1], e);
    chk("b2b.initB", 512'(cap_init[m0+1]), 512'(1));

    // reset during WAIT of block 1
    m0 = n_pulse;
    send(32'h61626300, 1'b1, 3'd3);
    t = 0;
    while (n_pulse == m0 && t < 200) begin @(negedge clk); t++; end
    if (n_pulse == m0) tmo("rst.pulse");
    reset_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    m0 = n_pulse; d0 = n_done;
    send(32'h61626300, 1'b1, 3'd3);
    wait_done(d0 + 1);
    e = '0; e[0] = 32'h61626380; e[15] = 32'h18;
    chk("rst.init",  512'(cap_init[m0]), 512'(1));
    chk("rst.block", cap[m0], e);

    // protocol error: s_nbytes > 4
    d0 = n_done;
    send(32'hDEADBEEF, 1'b1, 3'd5);
`ifdef SHA1_PADDER_ERR_EN
    chk("err.set", 512'(err), 512'(1));
`else
    chk("err.tied", 512'(err), 512'(0));
`endif
    wait_done(d0 + 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
